// File: rtl/gpio_bus_arbiter.sv
// gpio_bus_arbiter: shares the GPIO register port between two masters (m0 = CPU
// load/store path, m1 = debug/pattern engine) and sequences each access, including
// the extra cycle needed for GPIO's registered read data.
//
// Build option: define GPIO_ARB_ADDR_CHECK_EN to range-check the winning address
// against MAX_ADDR. Out-of-range accesses never reach GPIO and complete through an
// ERR state with mN_err=1. Without the macro every address is forwarded and mN_err
// is tied low.
module gpio_bus_arbiter #(
    parameter int unsigned       ADDR_W     = 16,
    parameter int unsigned       DATA_W     = 32,
    parameter int unsigned       FIXED_PRIO = 0,
    parameter logic [ADDR_W-1:0] MAX_ADDR   = ADDR_W'(1)
) (
    input  logic              clk,
    input  logic              rst,
    // master 0
    input  logic              m0_req,
    input  logic [3:0]        m0_we,
    input  logic              m0_re,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_ack,
    output logic [DATA_W-1:0] m0_rdata,
    output logic              m0_err,
    // master 1
    input  logic              m1_req,
    input  logic [3:0]        m1_we,
    input  logic              m1_re,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_ack,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              m1_err,
    // GPIO register port
    output logic              gpio_ce,
    output logic [3:0]        bus_we,
    output logic              bus_re,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic [DATA_W-1:0] bus_rdata
);

    typedef enum logic [1:0] {
`ifdef GPIO_ARB_ADDR_CHECK_EN
        ST_ERR    = 2'd3,
`endif
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RDATA  = 2'd2
    } state_e;

    state_e state_q, state_d;
    // Granted master: 0 = m0, 1 = m1.
    logic   grant_q, grant_d;
    // Master that completed most recently; reset to m1 so m0 wins the first tie.
    logic   last_q, last_d;

    // Fields of the granted master's request (held stable by the master until ack).
    logic [3:0]        sel_we;
    logic              sel_re;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              sel_is_read;

    // Arbitration result for the current IDLE cycle.
    logic              win;

    // Completion signals before steering to the granted master.
    logic              ack_c;
    logic [DATA_W-1:0] rdata_c;

`ifdef GPIO_ARB_ADDR_CHECK_EN
    logic              err_c;
    logic [ADDR_W-1:0] win_addr;
`else
    // MAX_ADDR only matters when the range check is built in.
    logic              unused_max_addr;
    assign unused_max_addr = ^MAX_ADDR;
`endif

    // Mux the granted master's request onto the internal select bus.
    always_comb begin
        sel_we    = m0_we;
        sel_re    = m0_re;
        sel_addr  = m0_addr;
        sel_wdata = m0_wdata;
        if (grant_q) begin
            sel_we    = m1_we;
            sel_re    = m1_re;
            sel_addr  = m1_addr;
            sel_wdata = m1_wdata;
        end
        // Any byte enable makes it a write; re alone makes it a read.
        sel_is_read = (sel_we == 4'b0000) && sel_re;
    end

    // Pick the winner: single requester wins, ties go to fixed m0 or to the
    // master that did not complete last.
    always_comb begin
        win = 1'b0;
        if (m0_req && m1_req) begin
            win = (FIXED_PRIO != 0) ? 1'b0 : ~last_q;
        end else if (m1_req) begin
            win = 1'b1;
        end
`ifdef GPIO_ARB_ADDR_CHECK_EN
        win_addr = win ? m1_addr : m0_addr;
`endif
    end

    // Next-state logic for the access sequencer and round-robin history.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        unique case (state_q)
            ST_IDLE: begin
                if (m0_req || m1_req) begin
                    grant_d = win;
                    state_d = ST_ACCESS;
`ifdef GPIO_ARB_ADDR_CHECK_EN
                    if (win_addr > MAX_ADDR) begin
                        state_d = ST_ERR;
                    end
`endif
                end
            end
            ST_ACCESS: begin
                if (sel_is_read) begin
                    state_d = ST_RDATA;
                end else begin
                    state_d = ST_IDLE;
                    last_d  = grant_q;
                end
            end
            ST_RDATA: begin
                state_d = ST_IDLE;
                last_d  = grant_q;
            end
`ifdef GPIO_ARB_ADDR_CHECK_EN
            ST_ERR: begin
                state_d = ST_IDLE;
                last_d  = grant_q;
            end
`endif
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, grant and round-robin history registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            grant_q <= 1'b0;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
        end
    end

    // Decode bus drive and completion from the registered state.
    always_comb begin
        gpio_ce   = 1'b0;
        bus_we    = 4'b0000;
        bus_re    = 1'b0;
        bus_addr  = '0;
        bus_wdata = '0;
        ack_c     = 1'b0;
        rdata_c   = '0;
`ifdef GPIO_ARB_ADDR_CHECK_EN
        err_c     = 1'b0;
`endif
        unique case (state_q)
            ST_ACCESS: begin
                gpio_ce   = 1'b1;
                bus_we    = sel_we;
                bus_re    = sel_is_read;
                bus_addr  = sel_addr;
                bus_wdata = sel_wdata;
                // Writes complete here; GPIO captures at the end of this cycle.
                ack_c     = ~sel_is_read;
            end
            ST_RDATA: begin
                // GPIO read data is registered, so it appears one cycle after the strobe.
                gpio_ce   = 1'b1;
                bus_re    = 1'b1;
                bus_addr  = sel_addr;
                rdata_c   = bus_rdata;
                ack_c     = 1'b1;
            end
`ifdef GPIO_ARB_ADDR_CHECK_EN
            ST_ERR: begin
                ack_c     = 1'b1;
                err_c     = 1'b1;
            end
`endif
            default: begin
            end
        endcase
    end

    // Steer completion to the granted master only.
    assign m0_ack   = ack_c & ~grant_q;
    assign m1_ack   = ack_c &  grant_q;
    assign m0_rdata = m0_ack ? rdata_c : '0;
    assign m1_rdata = m1_ack ? rdata_c : '0;
`ifdef GPIO_ARB_ADDR_CHECK_EN
    assign m0_err   = err_c & ~grant_q;
    assign m1_err   = err_c &  grant_q;
`else
    assign m0_err   = 1'b0;
    assign m1_err   = 1'b0;
`endif

endmodule

// File: tb/tb_gpio_bus_arbiter.sv
// tb_gpio_bus_arbiter: directed scenarios plus randomized traffic checked against a
// transaction-level model (arbitration rule, access latency, word memory).
module tb_gpio_bus_arbiter;

    localparam int unsigned ADDR_W   = 16;
    localparam int unsigned DATA_W   = 32;
    localparam logic [15:0] MAX_ADDR = 16'h0001;
`ifdef GPIO_ARB_ADDR_CHECK_EN
    localparam bit CHECK_EN = 1'b1;
`else
    localparam bit CHECK_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;

    // Round-robin instance
    logic [1:0]             req;
    logic [1:0][3:0]        we;
    logic [1:0]             re;
    logic [1:0][ADDR_W-1:0] addr;
    logic [1:0][DATA_W-1:0] wdata;
    logic [1:0]             ack;
    logic [1:0][DATA_W-1:0] rdata;
    logic [1:0]             err;
    logic                   gpio_ce;
    logic [3:0]             bus_we;
    logic                   bus_re;
    logic [ADDR_W-1:0]      bus_addr;
    logic [DATA_W-1:0]      bus_wdata;
    logic [DATA_W-1:0]      bus_rdata;

    // Fixed-priority instance
    logic [1:0]             f_req;
    logic [1:0][3:0]        f_we;
    logic [1:0]             f_re;
    logic [1:0][ADDR_W-1:0] f_addr;
    logic [1:0][DATA_W-1:0] f_wdata;
    logic [1:0]             f_ack;
    logic [1:0]             f_err;
    logic                   f_gpio_ce;
    logic [1:0][DATA_W-1:0] unused_f_rdata;
    logic [3:0]             unused_f_bus_we;
    logic                   unused_f_bus_re;
    logic [ADDR_W-1:0]      unused_f_bus_addr;
    logic [DATA_W-1:0]      unused_f_bus_wdata;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    logic [DATA_W-1:0] ref_mem [2];
    int                last_grant;

    always #5 clk = ~clk;

    gpio_bus_arbiter #(.ADDR_W(16), .DATA_W(32), .FIXED_PRIO(0), .MAX_ADDR(16'h0001)) dut (
        .clk(clk), .rst(rst),
        .m0_req(req[0]), .m0_we(we[0]), .m0_re(re[0]), .m0_addr(addr[0]), .m0_wdata(wdata[0]),
        .m0_ack(ack[0]), .m0_rdata(rdata[0]), .m0_err(err[0]),
        .m1_req(req[1]), .m1_we(we[1]), .m1_re(re[1]), .m1_addr(addr[1]), .m1_wdata(wdata[1]),
        .m1_ack(ack[1]), .m1_rdata(rdata[1]), .m1_err(err[1]),
        .gpio_ce(gpio_ce), .bus_we(bus_we), .bus_re(bus_re), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_rdata(bus_rdata)
    );

    gpio_bus_arbiter #(.ADDR_W(16), .DATA_W(32), .FIXED_PRIO(1), .MAX_ADDR(16'h0001)) dut_fp (
        .clk(clk), .rst(rst),
        .m0_req(f_req[0]), .m0_we(f_we[0]), .m0_re(f_re[0]), .m0_addr(f_addr[0]), .m0_wdata(f_wdata[0]),
        .m0_ack(f_ack[0]), .m0_rdata(unused_f_rdata[0]), .m0_err(f_err[0]),
        .m1_req(f_req[1]), .m1_we(f_we[1]), .m1_re(f_re[1]), .m1_addr(f_addr[1]), .m1_wdata(f_wdata[1]),
        .m1_ack(f_ack[1]), .m1_rdata(unused_f_rdata[1]), .m1_err(f_err[1]),
        .gpio_ce(f_gpio_ce), .bus_we(unused_f_bus_we), .bus_re(unused_f_bus_re),
        .bus_addr(unused_f_bus_addr), .bus_wdata(unused_f_bus_wdata), .bus_rdata(32'h0)
    );

    // GPIO slave: two word registers, byte-enabled writes, registered read data.
    logic [DATA_W-1:0] gpio_mem [2];
    logic [DATA_W-1:0] gpio_rd_q;
    always @(posedge clk) begin
        if (rst) begin
            gpio_mem[0] <= '0;
            gpio_mem[1] <= '0;
            gpio_rd_q   <= '0;
        end else begin
            if (gpio_ce && bus_addr < 16'd2) begin
                for (int b = 0; b < 4; b++) begin
                    if (bus_we[b]) gpio_mem[bus_addr[0]][8*b +: 8] <= bus_wdata[8*b +: 8];
                end
            end
            if (gpio_ce && bus_re) gpio_rd_q <= (bus_addr < 16'd2) ? gpio_mem[bus_addr[0]] : '0;
        end
    end
    assign bus_rdata = (gpio_ce && bus_re) ? gpio_rd_q : '0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req = '0; we = '0; re = '0; addr = '0; wdata = '0;
        f_req = '0; f_we = '0; f_re = '0; f_addr = '0; f_wdata = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        step();
        step();
        rst = 1'b0;
        ref_mem[0] = '0;
        ref_mem[1] = '0;
        last_grant = 1;
    endtask

    task automatic test_reset();
        ref_mem[0] = '0;
        ref_mem[1] = '0;
        rst = 1'b1;
        idle_inputs();
        req = 2'b11; re = 2'b11;
        step();
        step();
        checks++;
        if ({ack, err, gpio_ce, bus_we, bus_re} !== 9'b0 || bus_addr !== 16'h0 || bus_wdata !== 32'h0) begin
            failures++;
            $display("FAIL reset_outputs ack=%b err=%b ce=%b we=%h re=%b addr=%h wdata=%h exp all zero",
                     ack, err, gpio_ce, bus_we, bus_re, bus_addr, bus_wdata);
        end
        checks++;
        if (rdata !== '0) begin
            failures++;
            $display("FAIL reset_rdata got=%h exp=0", rdata);
        end
        rst = 1'b0;
        step();
        checks++;
        if (gpio_ce !== 1'b1 || bus_re !== 1'b1 || ack !== 2'b00) begin
            failures++;
            $display("FAIL reset_first_access ce=%b re=%b ack=%b exp ce=1 re=1 ack=00", gpio_ce, bus_re, ack);
        end
        step();
        checks++;
        if (ack !== 2'b01 || rdata[0] !== 32'h0) begin
            failures++;
            $display("FAIL reset_first_grant ack=%b rdata=%h exp ack=01 rdata=0", ack, rdata[0]);
        end
        step();
        req[0] = 1'b0; re[0] = 1'b0;
        step();
        step();
        checks++;
        if (ack !== 2'b10 || rdata[1] !== 32'h0) begin
            failures++;
            $display("FAIL reset_pending_m1 ack=%b rdata=%h exp ack=10 rdata=0", ack, rdata[1]);
        end
        step();
        idle_inputs();
    endtask

    task automatic test_write_read_m0();
        do_reset();
        req[0] = 1'b1; we[0] = 4'b1100; re[0] = 1'b0; addr[0] = 16'h0; wdata[0] = 32'hA5A5_0000;
        checks++;
        if (gpio_ce !== 1'b0) begin
            failures++;
            $display("FAIL m0_wr_idle_ce got=%b exp=0", gpio_ce);
        end
        step();
        checks++;
        if (ack !== 2'b01 || gpio_ce !== 1'b1 || bus_we !== 4'b1100 || bus_addr !== 16'h0 || bus_wdata !== 32'hA5A5_0000) begin
            failures++;
            $display("FAIL m0_wr_access ack=%b ce=%b we=%b addr=%h wdata=%h exp ack=01 ce=1 we=1100 addr=0 wdata=a5a50000",
                     ack, gpio_ce, bus_we, bus_addr, bus_wdata);
        end
        step();
        checks++;
        if (gpio_ce !== 1'b0 || ack !== 2'b00) begin
            failures++;
            $display("FAIL m0_wr_done ce=%b ack=%b exp ce=0 ack=00", gpio_ce, ack);
        end
        we[0] = 4'b0000; re[0] = 1'b1; wdata[0] = 32'h0;
        step();
        checks++;
        if (ack !== 2'b00 || bus_re !== 1'b1) begin
            failures++;
            $display("FAIL m0_rd_access ack=%b re=%b exp ack=00 re=1", ack, bus_re);
        end
        step();
        checks++;
        if (ack !== 2'b01 || rdata[0][31:16] !== 16'hA5A5 || err !== 2'b00 || rdata[1] !== 32'h0) begin
            failures++;
            $display("FAIL m0_rd_data ack=%b rdata=%h err=%b exp ack=01 rdata[31:16]=a5a5 err=00", ack, rdata[0], err);
        end
        step();
        idle_inputs();
    endtask

    task automatic test_write_read_m1();
        do_reset();
        req[1] = 1'b1; we[1] = 4'b1111; addr[1] = 16'h1; wdata[1] = 32'h0000_00FF;
        step();
        checks++;
        if (ack !== 2'b10 || bus_addr !== 16'h1) begin
            failures++;
            $display("FAIL m1_wr_ack ack=%b addr=%h exp ack=10 addr=1", ack, bus_addr);
        end
        step();
        we[1] = 4'b0000; re[1] = 1'b1; wdata[1] = 32'h0;
        step();
        step();
        checks++;
        if (ack !== 2'b10 || rdata[1] !== 32'h0000_00FF || rdata[0] !== 32'h0) begin
            failures++;
            $display("FAIL m1_rd_data ack=%b rdata=%h exp ack=10 rdata=000000ff", ack, rdata[1]);
        end
        step();
        idle_inputs();
    endtask

    task automatic test_round_robin();
        logic [1:0] exp_ack;
        do_reset();
        // we=0, re=0: zero-byte writes, acked after ACCESS.
        req = 2'b11; addr[1] = 16'h1;
        for (int k = 0; k < 4; k++) begin
            exp_ack = (k % 2 == 0) ? 2'b01 : 2'b10;
            step();
            checks++;
            if (ack !== exp_ack || bus_we !== 4'b0000) begin
                failures++;
                $display("FAIL rr_grant k=%0d got=%b exp=%b we=%b", k, ack, exp_ack, bus_we);
            end
            step();
        end
        idle_inputs();
    endtask

    task automatic test_fixed_prio();
        int cnt0;
        int cnt1;
        do_reset();
        cnt0 = 0;
        cnt1 = 0;
        f_req = 2'b11;
        for (int k = 1; k <= 8; k++) begin
            step();
            cnt0 += int'(f_ack[0]);
            cnt1 += int'(f_ack[1]);
            checks++;
            if (f_gpio_ce !== ((k % 2) == 1) || f_err !== 2'b00) begin
                failures++;
                $display("FAIL fp_ce k=%0d got=%b err=%b exp ce=%0d err=00", k, f_gpio_ce, f_err, (k % 2));
            end
        end
        checks++;
        if (cnt0 != 4 || cnt1 != 0) begin
            failures++;
            $display("FAIL fp_counts m0=%0d m1=%0d exp m0=4 m1=0", cnt0, cnt1);
        end
        f_req[0] = 1'b0;
        step();
        checks++;
        if (f_ack !== 2'b10) begin
            failures++;
            $display("FAIL fp_m1_served got=%b exp=10", f_ack);
        end
        step();
        idle_inputs();
    endtask

    task automatic test_reset_mid_read();
        do_reset();
        req[0] = 1'b1;
        step();
        checks++;
        if (ack !== 2'b01) begin
            failures++;
            $display("FAIL rst_pre_write got=%b exp=01", ack);
        end
        step();
        re[0] = 1'b1;
        step();
        step();
        // In RDATA now: reset abandons the read.
        rst = 1'b1;
        step();
        checks++;
        if ({ack, err, gpio_ce, bus_we, bus_re} !== 9'b0 || bus_addr !== 16'h0 || bus_wdata !== 32'h0 || rdata !== '0) begin
            failures++;
            $display("FAIL rst_mid_read ack=%b ce=%b re=%b rdata=%h exp all zero", ack, gpio_ce, bus_re, rdata);
        end
        rst = 1'b0;
        idle_inputs();
        req = 2'b11;
        step();
        checks++;
        if (ack !== 2'b01) begin
            failures++;
            $display("FAIL rst_rr_favours_m0 got=%b exp=01", ack);
        end
        step();
        idle_inputs();
    endtask

    task automatic test_back_to_back();
        logic [DATA_W-1:0] v;
        do_reset();
        v = $urandom();
        req[0] = 1'b1; we[0] = 4'b1111; addr[0] = 16'h1; wdata[0] = v;
        checks++;
        if (gpio_ce !== 1'b0) begin
            failures++;
            $display("FAIL b2b_c1_ce got=%b exp=0", gpio_ce);
        end
        step();
        checks++;
        if (ack !== 2'b01 || gpio_ce !== 1'b1) begin
            failures++;
            $display("FAIL b2b_c2 ack=%b ce=%b exp ack=01 ce=1", ack, gpio_ce);
        end
        step();
        checks++;
        if (gpio_ce !== 1'b0 || ack !== 2'b00) begin
            failures++;
            $display("FAIL b2b_c3 ce=%b ack=%b exp ce=0 ack=00", gpio_ce, ack);
        end
        we[0] = 4'b0000; re[0] = 1'b1; wdata[0] = 32'h0;
        step();
        checks++;
        if (gpio_ce !== 1'b1 || ack !== 2'b00) begin
            failures++;
            $display("FAIL b2b_c4 ce=%b ack=%b exp ce=1 ack=00", gpio_ce, ack);
        end
        step();
        checks++;
        if (gpio_ce !== 1'b1 || ack !== 2'b01 || rdata[0] !== v) begin
            failures++;
            $display("FAIL b2b_c5 ce=%b ack=%b rdata=%h exp ce=1 ack=01 rdata=%h", gpio_ce, ack, rdata[0], v);
        end
        step();
        idle_inputs();
    endtask

    task automatic test_addr_range();
        do_reset();
        req[1] = 1'b1; re[1] = 1'b1; addr[1] = 16'h0005;
        step();
`ifdef GPIO_ARB_ADDR_CHECK_EN
        checks++;
        if (ack !== 2'b10 || err !== 2'b10 || rdata[1] !== 32'h0 || gpio_ce !== 1'b0) begin
            failures++;
            $display("FAIL range_err ack=%b err=%b rdata=%h ce=%b exp ack=10 err=10 rdata=0 ce=0",
                     ack, err, rdata[1], gpio_ce);
        end
        step();
        checks++;
        if (gpio_ce !== 1'b0 || ack !== 2'b00) begin
            failures++;
            $display("FAIL range_after ce=%b ack=%b exp ce=0 ack=00", gpio_ce, ack);
        end
`else
        checks++;
        if (gpio_ce !== 1'b1 || bus_addr !== 16'h0005 || ack !== 2'b00) begin
            failures++;
            $display("FAIL range_fwd ce=%b addr=%h ack=%b exp ce=1 addr=0005 ack=00", gpio_ce, bus_addr, ack);
        end
        step();
        checks++;
        if (ack !== 2'b10 || err !== 2'b00 || rdata[1] !== 32'h0) begin
            failures++;
            $display("FAIL range_fwd_ack ack=%b err=%b rdata=%h exp ack=10 err=00 rdata=0", ack, err, rdata[1]);
        end
`endif
        step();
        idle_inputs();
    endtask

    task automatic test_random();
        logic [1:0]        pend;
        int                w;
        int                lat;
        bit                is_err;
        bit                is_rd;
        logic [1:0]        exp_ack;
        logic [DATA_W-1:0] exp_rd;
        do_reset();
        pend = 2'b00;
        for (int r = 0; r < 120; r++) begin
            checks++;
            if (gpio_ce !== 1'b0 || ack !== 2'b00 || bus_we !== 4'b0 || bus_re !== 1'b0 ||
                bus_addr !== 16'h0 || bus_wdata !== 32'h0) begin
                failures++;
                $display("FAIL rnd_idle r=%0d ce=%b ack=%b addr=%h exp idle zeros", r, gpio_ce, ack, bus_addr);
            end
            for (int i = 0; i < 2; i++) begin
                if (!pend[i] && $urandom_range(0, 2) != 0) begin
                    pend[i]  = 1'b1;
                    req[i]   = 1'b1;
                    we[i]    = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 15)) : 4'b0000;
                    re[i]    = 1'($urandom_range(0, 1));
                    addr[i]  = 16'($urandom_range(0, 3));
                    wdata[i] = $urandom();
                end
            end
            if (pend == 2'b00) begin
                pend[0] = 1'b1; req[0] = 1'b1; we[0] = 4'b0000; re[0] = 1'b1; addr[0] = 16'h0;
            end
            // Model: tie goes to the master that did not complete last.
            if (pend == 2'b11) w = 1 - last_grant;
            else               w = pend[1] ? 1 : 0;
            is_err = CHECK_EN && (addr[w] > MAX_ADDR);
            is_rd  = !is_err && (we[w] == 4'b0000) && re[w];
            lat    = is_rd ? 3 : 2;
            for (int c = 2; c <= lat; c++) begin
                step();
                exp_ack = (c == lat) ? (2'b01 << w) : 2'b00;
                checks++;
                if (ack !== exp_ack || gpio_ce !== !is_err) begin
                    failures++;
                    $display("FAIL rnd_ack r=%0d c=%0d ack=%b ce=%b exp ack=%b ce=%0d", r, c, ack, gpio_ce, exp_ack, !is_err);
                end
                if (c == 2 && !is_err) begin
                    checks++;
                    if (bus_addr !== addr[w] || bus_we !== we[w] || bus_re !== is_rd || bus_wdata !== wdata[w]) begin
                        failures++;
                        $display("FAIL rnd_bus r=%0d addr=%h we=%b re=%b wd=%h exp addr=%h we=%b re=%0d wd=%h",
                                 r, bus_addr, bus_we, bus_re, bus_wdata, addr[w], we[w], is_rd, wdata[w]);
                    end
                end
                if (c == lat) begin
                    exp_rd = (is_rd && addr[w] <= MAX_ADDR) ? ref_mem[addr[w][0]] : '0;
                    checks++;
                    if (rdata[w] !== exp_rd || rdata[1-w] !== 32'h0 || err[w] !== is_err || err[1-w] !== 1'b0) begin
                        failures++;
                        $display("FAIL rnd_data r=%0d m=%0d rdata=%h err=%b exp rdata=%h err=%0d",
                                 r, w, rdata[w], err, exp_rd, is_err);
                    end
                end
            end
            if (!is_err && !is_rd && addr[w] <= MAX_ADDR) begin
                for (int b = 0; b < 4; b++) begin
                    if (we[w][b]) ref_mem[addr[w][0]][8*b +: 8] = wdata[w][8*b +: 8];
                end
            end
            last_grant = w;
            pend[w]    = 1'b0;
            step();
            req[w] = 1'b0; we[w] = 4'b0000; re[w] = 1'b0;
        end
        idle_inputs();
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        last_grant = 1;
        test_reset();
        test_write_read_m0();
        test_write_read_m1();
        test_round_robin();
        test_fixed_prio();
        test_reset_mid_read();
        test_back_to_back();
        test_addr_range();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

endmodule
